aes_sequencer: RTL and testbench

Memory-mapped controller that sequences the shared AES core pair (encrypt/decrypt) on behalf of the CPU. Software loads 128-bit data and key words over a 32-bit request/acknowledge bus, then issues a start command with a mode bit. The block holds operands stable and enables the selected core for a fixed latency, captures the 128-bit result, and serves it back as four words. It sits beside the register file on the CPU's peripheral path.

---
 rtl/aes_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_aes_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sequencer.sv
// aes_sequencer: bus-mapped sequencer for the shared AES encrypt/decrypt core pair.
// Software loads DATA and KEY over a 32-bit REQ/ACK bus and writes CTRL.START.
// The selected core is then enabled for LATENCY cycles, and its output is
// captured into RESULT.
module aes_sequencer #(
  parameter int LATENCY = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ,
  input  logic         WR,
  input  logic [3:0]   ADDR,
  input  logic [31:0]  WDATA,
  output logic [31:0]  RDATA,
  output logic         ACK,
  output logic [127:0] AES_PT,
  output logic [127:0] AES_KEY,
  output logic         AES_EN_ENC,
  output logic         AES_EN_DEC,
  input  logic [127:0] AES_ENC_RES,
  input  logic [127:0] AES_DEC_RES,
  output logic         BUSY
);

  // Countdown load value. The RUN phase lasts cnt_load+1 cycles, i.e. LATENCY.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [127:0]  data_reg;
  logic [127:0]  key_reg;
  logic [127:0]  result_reg;
  logic [7:0]    cnt;
  logic          mode;
  logic          done;
  logic          err;

  logic          accept;
  logic          wr_go;
  logic          rd_go;
  logic          is_run;
  logic          start_cmd;
  logic          capture;
  logic          blocked_wr;
  logic          status_rd;
  logic          data_wr;
  logic          key_wr;
  logic [31:0]   rd_word;

  // Select 32-bit word idx of a 128-bit register; word 0 is the MSW.
  function automatic logic [31:0] word_get(input logic [127:0] v, input logic [1:0] idx);
    logic [31:0] r;
    case (idx)
      2'd0:    r = v[127:96];
      2'd1:    r = v[95:64];
      2'd2:    r = v[63:32];
      default: r = v[31:0];
    endcase
    return r;
  endfunction

  // Replace 32-bit word idx of a 128-bit register; word 0 is the MSW.
  function automatic logic [127:0] word_put(input logic [127:0] v, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // A new request is taken only while no acknowledge is outstanding.
  assign accept = REQ && !ACK;
  assign wr_go  = accept && WR;
  assign rd_go  = accept && !WR;
  assign is_run = (state == S_RUN);

  // START is honoured only outside RUN.
  assign start_cmd = wr_go && (ADDR == ADDR_CTRL) && WDATA[0] && !is_run;

  // The last RUN cycle is the one that sees cnt==0.
  assign capture = is_run && (cnt == 8'd0);

  // Operand and control writes during RUN are acknowledged but discarded, and flag err.
  assign blocked_wr = wr_go && is_run && (ADDR <= ADDR_CTRL);
  assign status_rd  = rd_go && (ADDR == ADDR_STATUS);
  assign data_wr    = wr_go && !is_run && (ADDR[3:2] == 2'b00);
  assign key_wr     = wr_go && !is_run && (ADDR[3:2] == 2'b01);

  // Operands go straight to both cores so they remain stable during RUN.
  assign AES_PT  = data_reg;
  assign AES_KEY = key_reg;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    BUSY       = 1'b0;
    AES_EN_ENC = 1'b0;
    AES_EN_DEC = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_cmd) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        BUSY       = 1'b1;
        AES_EN_ENC = !mode;
        AES_EN_DEC = mode;
        if (cnt == 8'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start_cmd) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state: mode latch, latency countdown, done and err flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode <= 1'b0;
      cnt  <= 8'd0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (start_cmd) begin
        mode <= WDATA[1];
        cnt  <= CNT_LOAD;
        done <= 1'b0;
      end else if (capture) begin
        done <= 1'b1;
      end else if (is_run) begin
        cnt <= cnt - 8'd1;
      end

      if (blocked_wr) begin
        err <= 1'b1;
      end else if (status_rd) begin
        err <= 1'b0;
      end
    end
  end

  // Operand registers and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg   <= '0;
      key_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (data_wr) begin
        data_reg <= word_put(data_reg, ADDR[1:0], WDATA);
      end
      if (key_wr) begin
        key_reg <= word_put(key_reg, ADDR[1:0], WDATA);
      end
      if (capture) begin
        result_reg <= mode ? AES_DEC_RES : AES_ENC_RES;
      end
    end
  end

  // Read-data mux. It samples the pre-edge state, so a STATUS read at the
  // capture edge still reports busy.
  always_comb begin
    rd_word = '0;
    case (ADDR)
      4'd0, 4'd1, 4'd2, 4'd3:     rd_word = word_get(data_reg, ADDR[1:0]);
      4'd4, 4'd5, 4'd6, 4'd7:     rd_word = word_get(key_reg, ADDR[1:0]);
      ADDR_STATUS:                rd_word = {29'd0, err, done, is_run};
      4'd12, 4'd13, 4'd14, 4'd15: rd_word = word_get(result_reg, ADDR[1:0]);
      default:                    rd_word = '0;
    endcase
  end

  // Bus response: one-cycle ACK with registered read data. RDATA is zero otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ACK   <= 1'b0;
      RDATA <= '0;
    end else begin
      ACK   <= accept;
      RDATA <= rd_go ? rd_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_aes_sequencer.sv
// Testbench for aes_sequencer. Instance "a" is built with LATENCY=10 and
// instance "b" with LATENCY=1; both share a clock. Read results are checked
// through an expected-value queue.
module tb_aes_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a (LATENCY = 10)
  logic         rst_a, req_a, wr_a, ack_a, en_enc_a, en_dec_a, busy_a;
  logic [3:0]   addr_a;
  logic [31:0]  wdata_a, rdata_a;
  logic [127:0] pt_a, key_a, enc_res_a, dec_res_a;
  // Instance b (LATENCY = 1)
  logic         rst_b, req_b, wr_b, ack_b, en_enc_b, en_dec_b, busy_b;
  logic [3:0]   addr_b;
  logic [31:0]  wdata_b, rdata_b;
  logic [127:0] pt_b, key_b, enc_res_b, dec_res_b;

  logic [127:0] vec_p = 128'h01020304_05060708_090a0b0c_0d0e0f10;
  logic [127:0] vec_k = 128'h02030405_06070809_0a0b0c0d_0e0f1011;
  logic [127:0] vec_c = 128'he4692b0c_e8037398_0afc9fe5_79f5ee9c;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rise_a = 0, fall_a = 0, rise_b = 0, fall_b = 0;
  int both_hi = 0;
  logic busy_a_q = 1'b0, busy_b_q = 1'b0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Core model: the known vector pair maps both ways; other operands use simple mixes.
  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] key);
    if (pt == vec_p && key == vec_k) return vec_c;
    return pt ^ key;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] pt, input logic [127:0] key);
    if (pt == vec_c && key == vec_k) return vec_p;
    return pt ^ ~key;
  endfunction

  assign enc_res_a = enc_model(pt_a, key_a);
  assign dec_res_a = dec_model(pt_a, key_a);
  assign enc_res_b = enc_model(pt_b, key_b);
  assign dec_res_b = dec_model(pt_b, key_b);

  aes_sequencer #(.LATENCY(10)) dut_a (
    .CLK(clk), .RST(rst_a), .REQ(req_a), .WR(wr_a), .ADDR(addr_a), .WDATA(wdata_a),
    .RDATA(rdata_a), .ACK(ack_a), .AES_PT(pt_a), .AES_KEY(key_a),
    .AES_EN_ENC(en_enc_a), .AES_EN_DEC(en_dec_a),
    .AES_ENC_RES(enc_res_a), .AES_DEC_RES(dec_res_a), .BUSY(busy_a)
  );

  aes_sequencer #(.LATENCY(1)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ(req_b), .WR(wr_b), .ADDR(addr_b), .WDATA(wdata_b),
    .RDATA(rdata_b), .ACK(ack_b), .AES_PT(pt_b), .AES_KEY(key_b),
    .AES_EN_ENC(en_enc_b), .AES_EN_DEC(en_dec_b),
    .AES_ENC_RES(enc_res_b), .AES_DEC_RES(dec_res_b), .BUSY(busy_b)
  );

  // Cycle counter, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // BUSY edge timestamps and the enable-exclusivity monitor.
  always @(negedge clk) begin
    busy_a_q <= busy_a;
    busy_b_q <= busy_b;
    if (busy_a && !busy_a_q) rise_a <= cyc;
    if (!busy_a && busy_a_q) fall_a <= cyc;
    if (busy_b && !busy_b_q) rise_b <= cyc;
    if (!busy_b && busy_b_q) fall_b <= cyc;
    if ((en_enc_a && en_dec_a) || (en_enc_b && en_dec_b)) both_hi <= both_hi + 1;
  end

  function automatic logic [31:0] wd(input logic [127:0] v, input int i);
    return v[(3 - i) * 32 +: 32];
  endfunction

  function automatic logic ack_of(input int idx);
    return (idx == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic [31:0] rdata_of(input int idx);
    return (idx == 0) ? rdata_a : rdata_b;
  endfunction

  function automatic logic busy_of(input int idx);
    return (idx == 0) ? busy_a : busy_b;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One bus transaction. It is entered on a negedge and returns on the negedge
  // where ACK is seen, with REQ already dropped.
  task automatic bus(input int idx, input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    if (idx == 0) begin req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d; end
    else          begin req_b = 1'b1; wr_b = w; addr_b = a; wdata_b = d; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_of(idx)) begin
        ok = 1'b1;
        rd = rdata_of(idx);
        break;
      end
    end
    if (idx == 0) req_a = 1'b0;
    else          req_b = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ok;
    bus(idx, 1'b1, a, d, rd, ok);
    check("wr_ack", 128'(ok), 128'(1));
  endtask

  task automatic rd(input int idx, input logic [3:0] a, input logic [31:0] e, input string tag);
    logic [31:0] got, ex;
    logic ok;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    bus(idx, 1'b0, a, 32'd0, got, ok);
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    check({t, "_ack"}, 128'(ok), 128'(1));
    if (ok) check(t, 128'(got), 128'(ex));
  endtask

  // Wait for BUSY to fall, then one more negedge so the edge monitor has updated.
  task automatic wait_idle(input int idx);
    for (int i = 0; i < 300 && busy_of(idx); i++) @(negedge clk);
    check("idle_timeout", 128'(busy_of(idx)), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    int nb, ne, nd;
    rst_a = 1'b1; req_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;

    // Reset held two cycles with a pending read request.
    @(negedge clk);
    req_a = 1'b1; wr_a = 1'b0; addr_a = 4'd9;
    repeat (2) @(negedge clk);
    check("rst_ack", 128'(ack_a), 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_rdata", 128'(rdata_a), 128'(0));
    check("rst_en", 128'({en_enc_a, en_dec_a}), 128'(0));
    check("rst_pt", pt_a, 128'(0));
    check("rst_key", key_a, 128'(0));
    check("rst_b_busy", 128'({busy_b, ack_b}), 128'(0));
    rst_a = 1'b0; rst_b = 1'b0; req_a = 1'b0;
    @(negedge clk);
    rd(0, 4'd9, 32'h0, "status_after_reset");

    // Encrypt.
    for (int i = 0; i < 4; i++) wr(0, 4'(i), wd(vec_p, i));
    for (int i = 0; i < 4; i++) wr(0, 4'(4 + i), wd(vec_k, i));
    check("pt_drive", pt_a, vec_p);
    check("key_drive", key_a, vec_k);
    rd(0, 4'd2, wd(vec_p, 2), "data2_readback");
    wr(0, 4'd8, 32'h1);
    nb = 0; ne = 0; nd = 0;
    for (int g = 0; g < 300 && busy_a; g++) begin
      nb++; ne += int'(en_enc_a); nd += int'(en_dec_a);
      @(negedge clk);
    end
    check("enc_busy_cycles", 128'(nb), 128'(10));
    check("enc_en_cycles", 128'(ne), 128'(10));
    check("enc_dec_en_cycles", 128'(nd), 128'(0));
    for (int i = 0; i < 4; i++) rd(0, 4'(12 + i), wd(vec_c, i), "enc_result");
    rd(0, 4'd9, 32'h2, "enc_status");

    // Decrypt.
    for (int i = 0; i < 4; i++) wr(0, 4'(i), wd(vec_c, i));
    wr(0, 4'd8, 32'h3);
    nb = 0; ne = 0; nd = 0;
    for (int g = 0; g < 300 && busy_a; g++) begin
      nb++; ne += int'(en_enc_a); nd += int'(en_dec_a);
      @(negedge clk);
    end
    check("dec_busy_cycles", 128'(nb), 128'(10));
    check("dec_en_cycles", 128'(nd), 128'(10));
    check("dec_enc_en_cycles", 128'(ne), 128'(0));
    for (int i = 0; i < 4; i++) rd(0, 4'(12 + i), wd(vec_p, i), "dec_result");
    rd(0, 4'd9, 32'h2, "dec_status");

    // Busy protection. Each transaction takes two cycles, so all of these land inside RUN.
    for (int i = 0; i < 4; i++) wr(0, 4'(i), wd(vec_p, i));
    wr(0, 4'd8, 32'h1);
    wr(0, 4'd0, 32'hFFFF_FFFF);
    wr(0, 4'd8, 32'h1);
    rd(0, 4'd9, 32'h5, "prot_status_err");
    rd(0, 4'd0, wd(vec_p, 0), "prot_data0_kept");
    rd(0, 4'd12, wd(vec_p, 0), "prot_result_prev");
    wait_idle(0);
    check("prot_run_len", 128'(fall_a - rise_a), 128'(10));
    rd(0, 4'd9, 32'h2, "prot_err_cleared");
    rd(0, 4'd12, wd(vec_c, 0), "prot_result");

    // Reset during RUN, together with a pending request.
    wr(0, 4'd8, 32'h1);
    repeat (3) @(negedge clk);
    check("mid_busy_before", 128'(busy_a), 128'(1));
    rst_a = 1'b1; req_a = 1'b1; wr_a = 1'b0; addr_a = 4'd9;
    @(negedge clk);
    check("mid_rst_busy", 128'(busy_a), 128'(0));
    check("mid_rst_en", 128'({en_enc_a, en_dec_a}), 128'(0));
    check("mid_rst_ack", 128'(ack_a), 128'(0));
    rst_a = 1'b0; req_a = 1'b0;
    @(negedge clk);
    rd(0, 4'd12, 32'h0, "mid_rst_result");
    rd(0, 4'd9, 32'h0, "mid_rst_status");
    rd(0, 4'd0, 32'h0, "mid_rst_data");
    for (int i = 0; i < 4; i++) wr(0, 4'(i), wd(vec_p, i));
    for (int i = 0; i < 4; i++) wr(0, 4'(4 + i), wd(vec_k, i));
    wr(0, 4'd8, 32'h1);
    wait_idle(0);
    check("fresh_run_len", 128'(fall_a - rise_a), 128'(10));
    rd(0, 4'd12, wd(vec_c, 0), "fresh_result0");
    rd(0, 4'd15, wd(vec_c, 3), "fresh_result3");

    // LATENCY=1 build: back-to-back STARTs from DONE.
    wr(1, 4'd3, 32'h0000_0011);
    wr(1, 4'd7, 32'h0000_0022);
    wr(1, 4'd8, 32'h1);
    wait_idle(1);
    check("l1_enc_len", 128'(fall_b - rise_b), 128'(1));
    rd(1, 4'd15, 32'h0000_0033, "l1_enc_result");
    rd(1, 4'd9, 32'h2, "l1_enc_status");
    wr(1, 4'd8, 32'h3);
    wait_idle(1);
    check("l1_dec_len", 128'(fall_b - rise_b), 128'(1));
    rd(1, 4'd15, 32'hFFFF_FFCC, "l1_dec_result");
    rd(1, 4'd9, 32'h2, "l1_dec_status");

    check("enables_exclusive", 128'(both_hi), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
